// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - opcodes, FSM encodings and helpers shared by the stack controller
package stack_ctrl_pkg;

    localparam logic [2:0] OP_PEEK       = 3'b000;
    localparam logic [2:0] OP_PUSH       = 3'b001;
    localparam logic [2:0] OP_POP        = 3'b010;
    localparam logic [2:0] OP_WRITE      = 3'b011;
    localparam logic [2:0] OP_PUSH_WRITE = 3'b101;
    localparam logic [2:0] OP_POP_WRITE  = 3'b110;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != 3'b100) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/stack_rr_arb2.sv
// rtl/stack_rr_arb2.sv - two-request round-robin arbiter with one-hot grant
module stack_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    // With no or both requests the grant points at prio, so an idle port still shows a ready.
    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = prio_q ? 2'b10 : 2'b01;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - two-port command sequencer driving the strobes of an external shift stack
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int N  = 5,
    parameter int DW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [2:0]    req_op0,
    input  logic [2:0]    req_op1,
    input  logic          req_data0,
    input  logic          req_data1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic          rsp_data,
    output logic          rsp_err,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_wr_en,
    output logic          stk_wr_data,
    input  logic [N-1:0]  stk_data,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic          id_q, id_d;
    logic          err_q, err_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic          wr_en_q, wr_en_d;
    logic          wr_data_q, wr_data_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          resp_first_q, resp_first_d;
    logic          rsp_data_q, rsp_data_d;

    logic [1:0]    grant;
    logic          hs;
    logic [2:0]    sel_op;
    logic          sel_data;
    logic          cmd_err;
    logic          unused_stk_bits;

    assign unused_stk_bits = ^stk_data;

    stack_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign sel_op    = grant[1] ? req_op1   : req_op0;
    assign sel_data  = grant[1] ? req_data1 : req_data0;

    assign full  = (depth_q == DW'(N));
    assign empty = (depth_q == '0);

    always_comb begin
        cmd_err = !op_is_legal(sel_op);
        if ((sel_op == OP_PUSH || sel_op == OP_PUSH_WRITE) && full) begin
            cmd_err = 1'b1;
        end
        if ((sel_op == OP_POP || sel_op == OP_POP_WRITE) && empty) begin
            cmd_err = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        err_d        = err_q;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        depth_d      = depth_q;
        resp_first_d = 1'b0;
        // The stack settles on the ISSUE->RESP edge, so its top bit is captured one cycle into RESP.
        rsp_data_d   = resp_first_q ? stk_data[0] : rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_ISSUE;
                    op_d      = sel_op;
                    id_d      = grant[1];
                    err_d     = cmd_err;
                    push_d    = !cmd_err && (sel_op == OP_PUSH || sel_op == OP_PUSH_WRITE);
                    pop_d     = !cmd_err && (sel_op == OP_POP || sel_op == OP_POP_WRITE);
                    wr_en_d   = !cmd_err && (sel_op == OP_WRITE || sel_op == OP_PUSH_WRITE ||
                                             sel_op == OP_POP_WRITE);
                    wr_data_d = sel_data;
                end
            end
            ST_ISSUE: begin
                state_d      = ST_RESP;
                resp_first_d = 1'b1;
                if (!err_q) begin
                    case (op_q)
                        OP_PUSH, OP_PUSH_WRITE: depth_d = depth_q + DW'(1);
                        OP_POP:                 depth_d = depth_q - DW'(1);
                        OP_WRITE: begin
                            if (depth_q == '0) depth_d = DW'(1);
                        end
                        OP_POP_WRITE: begin
                            if (depth_q > DW'(1)) depth_d = depth_q - DW'(1);
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_PEEK;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 1'b0;
            depth_q      <= '0;
            resp_first_q <= 1'b0;
            rsp_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            err_q        <= err_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            depth_q      <= depth_d;
            resp_first_q <= resp_first_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_err     = err_q;
    assign rsp_data    = resp_first_q ? stk_data[0] : rsp_data_q;
    assign stk_push    = push_q;
    assign stk_pop     = pop_q;
    assign stk_wr_en   = wr_en_q;
    assign stk_wr_data = wr_data_q;
    assign depth       = depth_q;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer and two-port arbiter for the N-bit shift stack. Accepts stack commands from two requesters over valid/ready handshakes and grants them round-robin. Drives the stack's push/pop/wr_en/wr_data strobes for exactly one cycle per command and tracks occupancy, rejecting overflow, underflow and illegal opcodes. Returns the resulting top-of-stack bit on a response channel. Sits between the instruction front-end and the `stack` instance.

## Interface
- `N`, default 5: stack depth in bits; must match the stack instance.
- `DW`, default $clog2(N+1): depth counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester command valid; bit i belongs to requester i.
- `req_ready` out 2: per-requester accept.
- `req_op0`, `req_op1` in 3 each: opcode from requester 0 and requester 1.
- `req_data0`, `req_data1` in 1 each: write bit from requester 0 and requester 1.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out 1: requester served.
- `rsp_data` out 1: top bit `stk_data[0]` after the operation.
- `rsp_err` out 1: command rejected.
- `stk_push`, `stk_pop`, `stk_wr_en`, `stk_wr_data` out 1 each: stack controls.
- `stk_data` in N: stack contents.
- `depth` out DW: occupied entries, 0..N.
- `full` out 1: asserted when `depth==N`.
- `empty` out 1: asserted when `depth==0`.

## Operation
- Opcodes:
  - 000 PEEK
  - 001 PUSH
  - 010 POP
  - 011 WRITE
  - 101 PUSH_WRITE
  - 110 POP_WRITE
  - 100 and 111 are illegal.
- Strobes and depth effect per opcode:
  - PUSH: `stk_push`; depth+1; if `depth==N`, overflow error.
  - POP: `stk_pop`; depth-1; if `depth==0`, underflow error.
  - WRITE: `stk_wr_en`; `stk_wr_data`=data; depth unchanged, except depth 0 becomes 1.
  - PUSH_WRITE: `stk_push`+`stk_wr_en`; depth+1; if `depth==N`, overflow error.
  - POP_WRITE: `stk_pop`+`stk_wr_en`; depth becomes max(depth-1,1); if `depth==0`, underflow error.
  - PEEK: no strobes; never errors.
- Rejected commands: no strobes asserted, depth unchanged, `rsp_err=1`, `rsp_data` still reports the current top bit.
- FSM:
  - IDLE: `req_ready` is asserted only for the granted requester. On handshake, latch op, data and id, then go to ISSUE.
  - ISSUE: exactly one cycle. Strobes are asserted and depth is updated at the end of the cycle. Go to RESP.
  - RESP: `rsp_valid=1`; `rsp_data` and `rsp_err` are registered and stable. On `rsp_ready`, return to IDLE.
- Arbitration:
  - Round-robin pointer `prio`.
  - If both requesters are valid, grant `prio`. If one is valid, grant that one.
  - After each accepted command, `prio` becomes the other requester.
  - `req_ready` is 0 outside IDLE.
- `rsp_data` is sampled from `stk_data[0]` during the RESP entry cycle, i.e. after the stack update.

## Timing
- Reset values: state IDLE, `prio=0`, `depth=0`, `empty=1`, `full=0`; all stack strobes 0; `rsp_valid`, `rsp_data`, `rsp_err`, `rsp_id` all 0; `req_ready=2'b01` (IDLE, prio 0).
- Latency from a handshake in cycle k:
  - Strobes are high in cycle k+1 only.
  - `rsp_valid` rises in cycle k+2.
  - Minimum command period is 3 cycles when `rsp_ready` is held high.
- Strobes are registered outputs and never glitch or stay high beyond ISSUE.
- `depth`, `full` and `empty` change only at the end of ISSUE.
- `rsp_ready` stalls hold RESP indefinitely: no new grant, response held stable.
- `req_valid` deasserted before the handshake: nothing is latched; the requester may change its op freely.
- Asynchronous reset mid-operation, in any state:
  - Return to IDLE immediately.
  - Strobes drop without waiting for a clock.
  - The pending response is discarded.
  - depth clears to 0; the stack shares the same reset.

## Structure
- Package `stack_ctrl_pkg`: opcode localparams (OP_PEEK…OP_POP_WRITE), FSM state encodings (IDLE/ISSUE/RESP), opcode-legality helper function.
- Sub-module `stack_rr_arb2`: two-request round-robin arbiter.
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `grant`, internal `prio` register.
- The controller instantiates the arbiter and drives the external `stack` instance; it does not contain the stack.

## Test plan
- **Reset:** hold `reset=0` → `req_ready=01`, `depth=0`, `empty=1`; all strobes and `rsp_valid` are 0.
- **Write then push-write:** req0 WRITE 1, then PUSH_WRITE 1 → stack reads 00001, then 00011; `depth` goes 1 then 2; responses report `rsp_data=1`, `rsp_err=0`; strobes are one cycle each at k+1.
- **Fill to N=5 then PUSH:** → `full=1`; the extra PUSH returns `rsp_err=1` with no `stk_push` pulse and `depth` staying 5.
  - From empty, POP → `rsp_err=1`; POP_WRITE 0 at depth 2 → stack 00000, `depth=1`.
- **Contention:** both requesters valid every cycle → grants alternate 0,1,0,1; `rsp_id` matches each grant; no grant while in ISSUE or RESP.
- **Response back-pressure:** `rsp_ready=0` for 4 cycles → FSM stays in RESP with `rsp_*` stable, `req_ready=00`; IDLE is re-entered one cycle after `rsp_ready=1`.
- **Reset and illegal opcodes:**
  - Assert `reset` during ISSUE → `stk_push` drops immediately, `rsp_valid` never rises, `depth=0`.
  - Op 100 → `rsp_err=1`, no strobes.
